// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// Optional ready-timeout logic is built only when RESET_SEQ_TIMEOUT_EN is defined.
package reset_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_DLY  = 2'd1,
        S_RDY  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    // Defaults on a 5 MHz clock basis (20 ms)
    localparam int unsigned DEF_NUM_STAGES    = 4;
    localparam int unsigned DEF_STAGE_DELAY   = 100_000;
    localparam int unsigned DEF_READY_TIMEOUT = 100_000;
    localparam int unsigned DEF_CNT_W         = 17;

    // Width of a stage index; at least one bit even for a single stage
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter with an expire strobe when enabled at zero.
module reset_seq_timer
    import reset_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down while enabled, saturating at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register, cleared synchronously
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = en && (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES subsystem resets in ascending order, each after a fixed
// delay and only once the previous stage reports ready.
// Define RESET_SEQ_TIMEOUT_EN to build the sticky ready-timeout (seq_err) logic.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
    parameter int unsigned STAGE_DELAY   = DEF_STAGE_DELAY,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned READY_TIMEOUT = DEF_READY_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic                  seq_err
);

    localparam int unsigned IDX_W = idx_width(NUM_STAGES);

    // Elaboration-time parameter sanity
    if ((NUM_STAGES < 1) || (NUM_STAGES > 16)) begin : g_bad_stages
        $error("reset_sequencer: NUM_STAGES out of range 1..16");
    end
    if ((STAGE_DELAY < 1) || (64'(STAGE_DELAY) > (64'(1) << CNT_W))) begin : g_bad_delay
        $error("reset_sequencer: STAGE_DELAY must be >= 1 and fit CNT_W");
    end
    if ((READY_TIMEOUT < 1) || (64'(READY_TIMEOUT) > (64'(1) << CNT_W))) begin : g_bad_timeout
        $error("reset_sequencer: READY_TIMEOUT must be >= 1 and fit CNT_W");
    end

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  seq_done_q, seq_done_d;

    logic seq_clr;
    logic dly_load;
    logic dly_en;
    logic dly_expire_c;
    logic ready_c;
    logic timeout_c;

    // Timers are cleared by either reset source
    assign seq_clr = RST || restart;
    assign dly_en  = (state_q == S_DLY);
    assign ready_c = stage_ready[idx_q];

    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_dly_timer (
        .clk      (CLK),
        .rst      (seq_clr),
        .load     (dly_load),
        .load_val (CNT_W'(STAGE_DELAY - 1)),
        .en       (dly_en),
        .expire_c (dly_expire_c)
    );

`ifdef RESET_SEQ_TIMEOUT_EN
    logic tmo_load;
    logic tmo_en;
    logic tmo_expire_c;
    logic seq_err_q, seq_err_d;

    // Timeout window opens on the edge that releases the current stage
    assign tmo_load  = (state_q == S_DLY) && dly_expire_c;
    assign tmo_en    = (state_q == S_RDY);
    assign timeout_c = tmo_en && tmo_expire_c && !ready_c;

    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_tmo_timer (
        .clk      (CLK),
        .rst      (seq_clr),
        .load     (tmo_load),
        .load_val (CNT_W'(READY_TIMEOUT - 1)),
        .en       (tmo_en),
        .expire_c (tmo_expire_c)
    );

    // Sticky error: set on timeout, survives restart, cleared only by RST
    always_comb begin
        seq_err_d = seq_err_q;
        if (!restart && timeout_c) begin
            seq_err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge CLK) begin
        if (RST) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign timeout_c = 1'b0;
    assign seq_err   = 1'b0;
`endif

    // Next-state and next-output logic; restart overrides everything
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        seq_done_d = seq_done_q;
        dly_load   = 1'b0;

        case (state_q)
            S_HOLD: begin
                dly_load = 1'b1;
                state_d  = S_DLY;
            end
            S_DLY: begin
                if (dly_expire_c) begin
                    rst_out_d[idx_q] = 1'b0;
                    state_d          = S_RDY;
                end
            end
            S_RDY: begin
                if (ready_c || timeout_c) begin
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        seq_done_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        dly_load = 1'b1;
                        state_d  = S_DLY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        if (restart) begin
            state_d    = S_HOLD;
            idx_d      = '0;
            rst_out_d  = '1;
            seq_done_d = 1'b0;
            dly_load   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_HOLD;
            idx_q      <= '0;
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus a random
// phase, all compared against an event-time reference model.
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int D = 8;
    localparam int T = 32;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         restart;
    logic [N-1:0] stage_ready;
    logic [N-1:0] rst_out;
    logic         seq_done;
    logic         seq_err;

    reset_sequencer #(
        .NUM_STAGES    (N),
        .STAGE_DELAY   (D),
        .CNT_W         (17),
        .READY_TIMEOUT (T)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .restart     (restart),
        .stage_ready (stage_ready),
        .rst_out     (rst_out),
        .seq_done    (seq_done),
        .seq_err     (seq_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase 0 waiting for first quiet edge, 1 counting to a
    // release time, 2 waiting for ready, 3 finished
    logic [N-1:0] m_rst;
    bit           m_done;
    bit           m_err;
    int           m_phase;
    int           m_k;
    int           m_rel_at;
    int           m_wait_start;
    int           rel_cyc [N];

    // Ready stimulus controls
    int lat [N];
    bit preset;
    bit noise;
    bit drop_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset(input bit clr_err);
        m_rst   = '1;
        m_done  = 1'b0;
        m_phase = 0;
        m_k     = 0;
        if (clr_err) m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at it
    task automatic model_edge(input bit r, input bit rs, input logic [N-1:0] rdy);
        bit to;
        if (r || rs) begin
            model_reset(r);
        end else begin
            case (m_phase)
                0: begin
                    m_rel_at = cyc + D;
                    m_phase  = 1;
                end
                1: if (cyc == m_rel_at) begin
                    m_rst[m_k]   = 1'b0;
                    rel_cyc[m_k] = cyc;
                    m_wait_start = cyc;
                    m_phase      = 2;
                end
                2: begin
                    to = TMO && ((cyc - m_wait_start) >= T);
                    if (rdy[m_k] || to) begin
                        if (!rdy[m_k]) m_err = 1'b1;
                        if (m_k == N - 1) begin
                            m_done  = 1'b1;
                            m_phase = 3;
                        end else begin
                            m_k++;
                            m_rel_at = cyc + D;
                            m_phase  = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Ready pattern for the coming edge, derived from the model's release times
    function automatic logic [N-1:0] next_ready();
        logic [N-1:0] v;
        bit accepted;
        for (int k = 0; k < N; k++) begin
            accepted = m_done || (k < m_k);
            if (preset) v[k] = 1'b1;
            else if (m_rst[k] == 1'b0) begin
                if (accepted && drop_en) v[k] = 1'($urandom % 2);
                else v[k] = ((cyc - rel_cyc[k]) >= lat[k]);
            end else begin
                v[k] = noise ? ($urandom % 4 == 0) : 1'b0;
            end
        end
        return v;
    endfunction

    // One clock: drive on negedge, update model at posedge, compare just after
    task automatic cycle(input bit r, input bit rs);
        @(negedge CLK);
        RST         = r;
        restart     = rs;
        stage_ready = next_ready();
        @(posedge CLK);
        cyc++;
        model_edge(r, rs, stage_ready);
        #1;
        check("rst_out", 32'(rst_out), 32'(m_rst));
        check("seq_done", 32'(seq_done), 32'(m_done));
        check("seq_err", 32'(seq_err), 32'(m_err));
    endtask

    task automatic run_until_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (seq_done === 1'b1) break;
            cycle(1'b0, 1'b0);
        end
    endtask

    initial begin
        int t0;
        int r;
        RST         = 1'b1;
        restart     = 1'b0;
        stage_ready = '0;
        preset      = 1'b0;
        noise       = 1'b0;
        drop_en     = 1'b0;
        m_err       = 1'b0;
        m_rel_at    = 0;
        m_wait_start = 0;
        model_reset(1'b1);
        for (int k = 0; k < N; k++) begin
            lat[k]     = 2;
            rel_cyc[k] = 0;
        end

        // Power-on with prompt ready responses
        repeat (5) cycle(1'b1, 1'b0);
        check("s1_reset_rst_out", 32'(rst_out), 32'hF);
        run_until_done(200);
        check("s1_done", 32'(seq_done), 32'd1);
        check("s1_all_released", 32'(rst_out), 32'd0);

        // Stage 1 never reports ready
        cycle(1'b1, 1'b0);
        lat[1] = 1_000_000;
        repeat (150) cycle(1'b0, 1'b0);
`ifdef RESET_SEQ_TIMEOUT_EN
        check("s2_stall_rst_out", 32'(rst_out), 32'h0);
        check("s2_stall_done", 32'(seq_done), 32'd1);
        check("s2_stall_err", 32'(seq_err), 32'd1);
`else
        check("s2_stall_rst_out", 32'(rst_out), 32'hC);
        check("s2_stall_done", 32'(seq_done), 32'd0);
        check("s2_stall_err", 32'(seq_err), 32'd0);
`endif

        // Restart keeps the error flag, RST together with restart clears it
        cycle(1'b0, 1'b1);
        check("s5_restart_rst_out", 32'(rst_out), 32'hF);
        check("s5_restart_err", 32'(seq_err), 32'(TMO));
        lat[1] = 2;
        run_until_done(200);
        check("s5_rerun_done", 32'(seq_done), 32'd1);
        check("s5_rerun_err", 32'(seq_err), 32'(TMO));
        cycle(1'b1, 1'b1);
        check("s5_both_err", 32'(seq_err), 32'd0);
        check("s5_both_rst_out", 32'(rst_out), 32'hF);

        // RST pulse with only stage 3 still held
        for (int i = 0; i < 200; i++) begin
            if (m_rst == 4'b1000) break;
            cycle(1'b0, 1'b0);
        end
        check("s4_reached_1000", 32'(rst_out), 32'h8);
        cycle(1'b1, 1'b0);
        check("s4_rst_rst_out", 32'(rst_out), 32'hF);
        check("s4_rst_done", 32'(seq_done), 32'd0);
        run_until_done(200);
        check("s4_replay_done", 32'(seq_done), 32'd1);

        // All ready bits preset: total latency is 4*D + 4
        preset = 1'b1;
        repeat (3) cycle(1'b1, 1'b0);
        t0 = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0);
            if (seq_done === 1'b1) break;
        end
        check("s6_latency", 32'(cyc - t0), 32'(4 * D + 4));
        preset = 1'b0;

        // Random phase: noisy ready, drops after acceptance, stray resets
        noise   = 1'b1;
        drop_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                for (int k = 0; k < N; k++)
                    lat[k] = ($urandom % 6 == 0) ? 45 : int'($urandom % 6);
            end
            r = int'($urandom % 400);
            cycle(r == 0, (r == 1) || (r == 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the debounced board-reset recovery stage.
- Takes the recovered, stable reset and releases NUM_STAGES subsystem resets one at a time, in fixed order.
- Each stage is released after a programmable delay, and only once the previous stage reports ready.
- Gives the chip a deterministic power-on/reset-release order with a single completion flag.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; legal range 1..16.
- STAGE_DELAY, 100_000: CLK cycles between a release trigger and the next stage's deassertion (20 ms at 5 MHz); must be >= 1.
- CNT_W, 17: counter width; must hold both STAGE_DELAY and READY_TIMEOUT.
- READY_TIMEOUT, 100_000: cycles to wait for stage_ready before declaring an error; used only with the optional feature.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  one clock; reset is synchronous and active-high. Driven by the reset recovery stage.
- restart  input  1  single-cycle pulse; re-asserts all stages and reruns the sequence.
- stage_ready  input  NUM_STAGES  bit k high = subsystem k is out of reset and operational.
- rst_out  output  NUM_STAGES  active-high reset to subsystem k.
- seq_done  output  1  high once every stage is released and ready.
- seq_err  output  1  sticky ready-timeout flag (optional feature).

Behaviour:
- Reset (RST=1 sampled at an edge), effective at that edge:
  - rst_out = all ones; seq_done = 0; seq_err = 0.
  - stage index = 0; counter = 0; state = S_HOLD.
- States:
  - S_HOLD: entered from reset or restart. On the first edge with RST=0, load counter = STAGE_DELAY-1 and go to S_DLY.
  - S_DLY: decrement counter each edge. At the edge where counter==0, clear rst_out[idx] (registered), go to S_RDY.
  - S_RDY: wait for stage_ready[idx]=1.
    - If idx < NUM_STAGES-1: idx++, load counter = STAGE_DELAY-1, go to S_DLY.
    - If idx == NUM_STAGES-1: go to S_DONE.
  - S_DONE: seq_done=1 (registered, asserted on the edge after the final ready is sampled). Remain here until RST or restart.
- Latency:
  - If RST is first sampled 0 at edge t0, rst_out[0] is low after edge t0+STAGE_DELAY.
  - If stage_ready[k] is first sampled 1 at edge t, rst_out[k+1] is low after edge t+STAGE_DELAY.
- Release order is strictly ascending. A released stage is never re-asserted except by RST or restart.
- stage_ready bits for stages not yet released are ignored. A ready that is already high when its stage releases is accepted on the next S_RDY edge.
- Ready dropping after acceptance is ignored: no re-sequencing, and seq_done stays 1.
- restart=1 in any state: same effect as reset except seq_err is retained. Sequence resumes from S_HOLD on the next edge with RST=0 and restart=0.
- RST and restart together: RST wins (seq_err cleared).
- RST asserted mid-sequence: all stages re-asserted at that edge; sequence restarts from stage 0.
- No combinational path from input to output; all outputs are registered.

Optional Feature:
- Macro: RESET_SEQ_TIMEOUT_EN.
- Defined:
  - In S_RDY, a timeout counter counts from 0.
  - If stage_ready[idx] is not seen within READY_TIMEOUT cycles, set seq_err=1 (sticky until RST) and advance exactly as if ready had arrived.
  - seq_done still asserts at the end.
- Undefined:
  - S_RDY waits indefinitely.
  - seq_err is tied to 0 and no timeout logic is built.

Decomposition:
- Package reset_seq_pkg:
  - state enum: S_HOLD, S_DLY, S_RDY, S_DONE.
  - default constants for STAGE_DELAY and READY_TIMEOUT (5 MHz basis).
  - CNT_W.
  - stage-index width function clog2(NUM_STAGES).
- One sub-module: reset_seq_timer.
  - Interface: load + load value, down-count, expire pulse.
  - Instanced once for the stage delay, and once more for the timeout when the macro is defined.

Test Plan:
All scenarios use NUM_STAGES=4, STAGE_DELAY=8, READY_TIMEOUT=32.
1. Power-on: RST high 5 cycles, then low; stage_ready[k] tied high 2 cycles after rst_out[k] falls -> rst_out 4'b1111 -> 1110 at t0+8, 1100, 1000, 0000 at 8-cycle spacing after each ready; seq_done high 1 cycle after ready[3] is sampled.
2. Stalled ready: hold stage_ready[1]=0 forever, macro off -> rst_out stays 4'b1100, seq_done=0, seq_err=0 indefinitely.
3. Same stall with RESET_SEQ_TIMEOUT_EN -> seq_err=1 32 cycles into S_RDY; rst_out[2] low 8 cycles later; seq_done eventually 1 with seq_err still 1.
4. RST pulse while rst_out=4'b1000 -> rst_out=4'b1111 at that edge, seq_done=0; full sequence replays from stage 0.
5. restart pulse in S_DONE with seq_err=1 -> rst_out=4'b1111, seq_err stays 1; sequence reruns. RST and restart in the same cycle -> seq_err cleared.
6. stage_ready=4'b1111 preset before release -> each stage accepted on its first S_RDY edge; total time from RST low to seq_done = 4*8 + 4 cycles.
